// File: rtl/lcd_rgb_tx_if.sv
// Signal bundle between lcd_rgb_tx, its upstream pixel source and the LCD pads.
// master = lcd_rgb_tx, slave = pixel source / pad ring.
`timescale 1ns/1ps
interface lcd_rgb_tx_if;
    logic [15:0] pixel_data;
    logic        data_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [15:0] lcd_rgb_o;
    logic        lcd_rgb_oe;
    logic        id_sample;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic        lcd_bl;
    logic        frame_start;

    modport master (
        input  pixel_data,
        output data_req, pixel_xpos, pixel_ypos,
        output lcd_rgb_o, lcd_rgb_oe, id_sample,
        output lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start
    );

    modport slave (
        output pixel_data,
        input  data_req, pixel_xpos, pixel_ypos,
        input  lcd_rgb_o, lcd_rgb_oe, id_sample,
        input  lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start
    );
endinterface

// File: rtl/lcd_rgb_tx.sv
// RGB LCD parallel-bus transmitter: HS/VS/DE timing, pixel requests, bus drive.
// Define LCD_ID_RELEASE_EN to hold the bus released after reset for panel ID sampling.
`timescale 1ns/1ps
module lcd_rgb_tx #(
    parameter int H_SYNC         = 128,
    parameter int H_BACK         = 88,
    parameter int H_DISP         = 800,
    parameter int H_FRONT        = 40,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int V_DISP         = 480,
    parameter int V_FRONT        = 10,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    lcd_rgb_tx_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_END = 11'(H_SYNC);
    localparam logic [10:0] VS_END = 11'(V_SYNC);
    localparam logic [10:0] HA_BEG = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HA_END = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] RQ_BEG = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] RQ_END = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] VA_BEG = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VA_END = 11'(V_SYNC + V_BACK + V_DISP);

    if (RELEASE_CYCLES < 2) begin : g_release_cycles_check
        $error("RELEASE_CYCLES must be at least 2");
    end

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        run;
    logic        rel_done;

`ifdef LCD_ID_RELEASE_EN
    localparam int REL_W = $clog2(RELEASE_CYCLES);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    typedef enum logic {S_RELEASE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RELEASE;
            rel_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        rel_done  = 1'b0;
        case (state_q)
            S_RELEASE: begin
                rel_cnt_d = rel_cnt_q + REL_W'(1);
                if (rel_cnt_q == REL_LAST) begin
                    rel_done = 1'b1;
                    state_d  = S_RUN;
                end
            end
            default: ;
        endcase
    end

    assign run = (state_q == S_RUN);
`else
    assign run      = 1'b1;
    assign rel_done = 1'b0;
`endif

    // NOTE: non-blocking assignments for every registered signal, including the reset branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (run) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
            end else begin
                h_cnt_d = h_cnt_q + 11'd1;
            end
        end
    end

    logic v_act, de, req;

    assign v_act = run && (v_cnt_q >= VA_BEG) && (v_cnt_q < VA_END);
    assign de    = v_act && (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END);
    // Requests run one pixel clock ahead of DE so registered upstream data lines up.
    assign req   = v_act && (h_cnt_q >= RQ_BEG) && (h_cnt_q < RQ_END);

    assign bus.data_req    = req;
    assign bus.pixel_xpos  = req ? h_cnt_q - RQ_BEG : '0;
    assign bus.pixel_ypos  = req ? v_cnt_q - VA_BEG : '0;
    assign bus.lcd_de      = de;
    assign bus.lcd_rgb_o   = de ? bus.pixel_data : '0;
    assign bus.lcd_rgb_oe  = run;
    assign bus.lcd_bl      = run;
    assign bus.id_sample   = rel_done;
    assign bus.lcd_hs      = ~(run && (h_cnt_q < HS_END));
    assign bus.lcd_vs      = ~(run && (v_cnt_q < VS_END));
    assign bus.frame_start = run && (h_cnt_q == '0) && (v_cnt_q == '0);
endmodule

// File: tb/tb_lcd_rgb_tx.sv
// Bench for lcd_rgb_tx on a 10x6 toy raster: release window, sync/DE timing, pixel
// scoreboard and a mid-frame reset. Works with LCD_ID_RELEASE_EN defined or not.
`timescale 1ns/1ps
module tb_lcd_rgb_tx;
    localparam int HS = 2, HB = 2, HD = 4, HF = 2;
    localparam int VS = 1, VB = 1, VD = 3, VF = 1;
    localparam int REL = 16;
    localparam int HT = HS + HB + HD + HF;  // 10
    localparam int VT = VS + VB + VD + VF;  // 6
    localparam int FRAME = HT * VT;         // 60
`ifdef LCD_ID_RELEASE_EN
    localparam int PRE = REL;
`else
    localparam int PRE = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    lcd_rgb_tx_if bus ();

    lcd_rgb_tx #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .RELEASE_CYCLES(REL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Registered upstream source; idle value is all-ones so an ungated bus is visible.
    always @(posedge clk) begin
        if (!rst_n)            bus.pixel_data <= 16'h0000;
        else if (bus.data_req) bus.pixel_data <= {bus.pixel_ypos[4:0], bus.pixel_xpos};
        else                   bus.pixel_data <= 16'hFFFF;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic valid = 1'b0;
    logic [15:0] sb[$];
    logic fs_seen = 1'b0;
    int fs_gap, de_cnt, rq_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Hand-computed vectors {valid, hs, vs, de, data_req, frame_start} by RUN cycle.
    function automatic logic [5:0] directed(input int rc);
        case (rc)
            0:       return 6'b1_00001;  // h0 v0
            13:      return 6'b1_11000;  // h3 v1: blank line
            23:      return 6'b1_11010;  // h3 v2: first request
            26:      return 6'b1_11110;  // h6 v2: last request, DE on
            27:      return 6'b1_11100;  // h7 v2: last DE
            44:      return 6'b1_11110;  // h4 v4
            48:      return 6'b1_11000;  // h8 v4: front porch
            51:      return 6'b1_01000;  // h1 v5: HS pulse
            60:      return 6'b1_00001;  // next frame start
            65:      return 6'b1_10000;  // h5 v0: VS pulse
            default: return 6'b0_00000;
        endcase
    endfunction

    initial begin : monitor
        int rc, h, v;
        logic run_e, e_id, e_hs, e_vs, e_de, e_rq, e_fs;
        logic [5:0] dv;
        logic [15:0] want;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                valid = 1'b1;
                cyc = 0;
                sb.delete();
                fs_seen = 1'b0;
            end else begin
                cyc++;
            end
            @(negedge clk);
            if (valid) begin
                run_e = (cyc >= PRE);
                rc = run_e ? cyc - PRE : 0;
`ifdef LCD_ID_RELEASE_EN
                e_id = (cyc == REL - 1);
`else
                e_id = 1'b0;
`endif
                h = rc % HT;
                v = (rc / HT) % VT;
                e_hs = !(run_e && h < HS);
                e_vs = !(run_e && v < VS);
                e_rq = run_e && v >= 2 && v < 5 && h >= 3 && h < 7;
                e_de = run_e && v >= 2 && v < 5 && h >= 4 && h < 8;
                e_fs = run_e && h == 0 && v == 0;

                check("oe", 32'(bus.lcd_rgb_oe), 32'(run_e));
                check("bl", 32'(bus.lcd_bl), 32'(run_e));
                check("id_sample", 32'(bus.id_sample), 32'(e_id));
                check("hs", 32'(bus.lcd_hs), 32'(e_hs));
                check("vs", 32'(bus.lcd_vs), 32'(e_vs));
                check("de", 32'(bus.lcd_de), 32'(e_de));
                check("data_req", 32'(bus.data_req), 32'(e_rq));
                check("frame_start", 32'(bus.frame_start), 32'(e_fs));
                check("xpos", 32'(bus.pixel_xpos), e_rq ? 32'(h - 3) : 32'd0);
                check("ypos", 32'(bus.pixel_ypos), e_rq ? 32'(v - 2) : 32'd0);

                dv = directed(rc);
                if (run_e && dv[5])
                    check("directed", 32'({bus.lcd_hs, bus.lcd_vs, bus.lcd_de,
                                           bus.data_req, bus.frame_start}), 32'(dv[4:0]));

                if (bus.lcd_de) begin
                    if (sb.size() == 0) begin
                        check("sb_empty", 32'(sb.size()), 32'd1);
                    end else begin
                        want = sb.pop_front();
                        check("pixel", 32'(bus.lcd_rgb_o), 32'(want));
                    end
                end else begin
                    check("rgb_idle", 32'(bus.lcd_rgb_o), 32'd0);
                end
                if (e_rq) sb.push_back({5'(v - 2), 11'(h - 3)});

                if (bus.frame_start) begin
                    if (fs_seen) begin
                        check("fs_period", 32'(fs_gap), 32'(FRAME));
                        check("de_per_frame", 32'(de_cnt), 32'(HD * VD));
                        check("req_per_frame", 32'(rq_cnt), 32'(HD * VD));
                    end
                    fs_seen = 1'b1;
                    fs_gap = 0;
                    de_cnt = 0;
                    rq_cnt = 0;
                end
                fs_gap++;
                de_cnt += int'(bus.lcd_de);
                rq_cnt += int'(bus.data_req);
            end
        end
    end

    initial begin : driver
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;                       // cycle 0 of the release window
        repeat (PRE + 2 * FRAME + 35) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;                       // RUN at v_cnt=3, h_cnt=5
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (PRE + 2 * FRAME + 10) @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
